// File: rtl/booth4_multiplier.sv
// Iterative radix-4 Booth multiplier: retires two multiplier bits per clock and
// produces the full 2*WIDTH-bit signed or unsigned product.
module booth4_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               op_start,
  input  logic               op_clear,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic [WIDTH-1:0]   multiplicand,
  output logic               op_busy,
  output logic               op_done,
  output logic [2*WIDTH-1:0] result
);

  localparam int MW = WIDTH + 2;       // extended operand width
  localparam int HW = WIDTH + 4;       // accumulator upper half (holds +/-2M sums)
  localparam int AW = 2 * WIDTH + 6;   // full accumulator
  localparam int CW = $clog2(WIDTH / 2 + 2);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t          state;
  logic [MW-1:0]   mcand;
  logic [MW:0]     mreg;               // extended multiplier plus guard bit m[-1]
  logic [AW-1:0]   acc, acc_nxt;
  logic [CW-1:0]   cnt;
  logic            sgn;
  logic [HW-1:0]   m_ext, term, upper;

  // Terms enter at bit WIDTH+2, so after N shifts the accumulator holds the
  // product scaled by 4 (signed, N=WIDTH/2) or by 1 (unsigned, N=WIDTH/2+1).
  always_comb begin
    m_ext = {{2{mcand[MW-1]}}, mcand};
    term  = '0;
    case (mreg[2:0])
      3'b001, 3'b010: term = m_ext;
      3'b011:         term = m_ext << 1;
      3'b100:         term = -(m_ext << 1);
      3'b101, 3'b110: term = -m_ext;
      default:        term = '0;
    endcase
    upper   = acc[AW-1 -: HW] + term;
    acc_nxt = {{2{upper[HW-1]}}, upper, acc[AW-HW-1:2]};
  end

  always_ff @(posedge clk) begin
    if (reset || op_clear) begin
      state   <= IDLE;
      op_busy <= 1'b0;
      op_done <= 1'b0;
      result  <= '0;
      cnt     <= '0;
      acc     <= '0;
      mcand   <= '0;
      mreg    <= '0;
      sgn     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (op_start) begin
          state   <= EXEC;
          op_busy <= 1'b1;
          sgn     <= signed_mode;
          acc     <= '0;
          if (signed_mode) begin
            mcand <= {{2{multiplicand[WIDTH-1]}}, multiplicand};
            mreg  <= {{2{multiplier[WIDTH-1]}}, multiplier, 1'b0};
            cnt   <= CW'(WIDTH / 2);
          end else begin
            mcand <= {2'b00, multiplicand};
            mreg  <= {2'b00, multiplier, 1'b0};
            cnt   <= CW'(WIDTH / 2 + 1);
          end
        end
        EXEC: begin
          acc  <= acc_nxt;
          mreg <= {{2{mreg[MW]}}, mreg[MW:2]};
          cnt  <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state   <= DONE;
            op_busy <= 1'b0;
            op_done <= 1'b1;
            result  <= sgn ? acc_nxt[2*WIDTH+1:2] : acc_nxt[2*WIDTH-1:0];
          end
        end
        DONE: ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth4_multiplier.sv
// Scoreboard bench for booth4_multiplier: WIDTH=32 directed cases and a WIDTH=8
// instance with randomised operands against a behavioural product.
module tb_booth4_multiplier;

  logic clk = 0;
  logic reset;
  always #5 clk = ~clk;

  logic        start32, clear32, sm32;
  logic [31:0] a32, b32;
  logic        busy32, done32;
  logic [63:0] res32;

  logic        start8, clear8, sm8;
  logic [7:0]  a8, b8;
  logic        busy8, done8;
  logic [15:0] res8;

  booth4_multiplier #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .op_start(start32), .op_clear(clear32),
    .signed_mode(sm32), .multiplier(a32), .multiplicand(b32),
    .op_busy(busy32), .op_done(done32), .result(res32));

  booth4_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .op_start(start8), .op_clear(clear8),
    .signed_mode(sm8), .multiplier(a8), .multiplicand(b8),
    .op_busy(busy8), .op_done(done8), .result(res8));

  int checks = 0;
  int errors = 0;
  logic [63:0] q32[$];
  logic [15:0] q8[$];

  function automatic logic [63:0] ref32(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic [63:0] ua, ub;
    sa = $signed(a); sb = $signed(b);
    ua = {32'b0, a}; ub = {32'b0, b};
    return s ? 64'(sa * sb) : ua * ub;
  endfunction

  function automatic logic [15:0] ref8(input logic s, input logic [7:0] a, input logic [7:0] b);
    logic signed [15:0] sa, sb;
    logic [15:0] ua, ub;
    sa = $signed(a); sb = $signed(b);
    ua = {8'b0, a}; ub = {8'b0, b};
    return s ? 16'(sa * sb) : ua * ub;
  endfunction

  // Pulse op_start; returns just after the start edge (T0 + 1 time unit).
  task automatic go32(input logic s, input logic [31:0] a, input logic [31:0] b);
    sm32 = s; a32 = a; b32 = b; start32 = 1;
    q32.push_back(ref32(s, a, b));
    @(posedge clk); #1 start32 = 0;
  endtask

  task automatic go8(input logic s, input logic [7:0] a, input logic [7:0] b);
    sm8 = s; a8 = a; b8 = b; start8 = 1;
    q8.push_back(ref8(s, a, b));
    @(posedge clk); #1 start8 = 0;
  endtask

  // Cycles until op_done, -1 if the bound expires.
  task automatic wait32(output int lat);
    lat = 0;
    while (!done32 && lat <= 40) begin @(posedge clk); #1 lat++; end
    if (!done32) lat = -1;
  endtask

  task automatic wait8(output int lat);
    lat = 0;
    while (!done8 && lat <= 20) begin @(posedge clk); #1 lat++; end
    if (!done8) lat = -1;
  endtask

  task automatic clr32();
    clear32 = 1; @(posedge clk); #1 clear32 = 0;
  endtask

  task automatic clr8();
    clear8 = 1; @(posedge clk); #1 clear8 = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    checks++;
    if ({busy32, done32, res32} !== 66'b0) begin
      errors++; $display("FAIL reset32 got busy=%b done=%b res=%h want 0 0 0", busy32, done32, res32);
    end
    checks++;
    if ({busy8, done8, res8} !== 18'b0) begin
      errors++; $display("FAIL reset8 got busy=%b done=%b res=%h want 0 0 0", busy8, done8, res8);
    end
  endtask

  task automatic test_directed32();
    int lat;
    logic [63:0] exp;
    logic [31:0] sa[4], sb[4];
    sa = '{32'd5, 32'd0, 32'hFFFFFFFB, 32'd0};
    sb = '{32'd0, 32'd5, 32'd0, 32'hFFFFFFFB};
    go32(1, 32'hFFFFFFFB, 32'hFFFFFFF9);
    checks++;
    if (busy32 !== 1'b1) begin errors++; $display("FAIL busy_after_start got %b want 1", busy32); end
    wait32(lat);
    exp = q32.pop_front();
    checks++;
    if (lat !== 16) begin errors++; $display("FAIL lat_signed got %0d want 16", lat); end
    checks++;
    if (res32 !== exp || busy32 !== 1'b0) begin
      errors++; $display("FAIL m5xm7 got %h busy=%b want %h busy=0", res32, busy32, exp);
    end
    repeat (3) @(posedge clk);
    #1 checks++;
    if (done32 !== 1'b1 || res32 !== exp) begin
      errors++; $display("FAIL done_hold got done=%b res=%h want 1 %h", done32, res32, exp);
    end
    clr32();
    checks++;
    if ({busy32, done32, res32} !== 66'b0) begin
      errors++; $display("FAIL clear_in_done got busy=%b done=%b res=%h want 0", busy32, done32, res32);
    end

    go32(1, 32'd9, 32'hFFFFFFFE);
    wait32(lat);
    exp = q32.pop_front();
    checks++;
    if (res32 !== exp) begin errors++; $display("FAIL 9xm2 got %h want %h", res32, exp); end
    clr32();

    go32(0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait32(lat);
    exp = q32.pop_front();
    checks++;
    if (lat !== 17) begin errors++; $display("FAIL lat_unsigned got %0d want 17", lat); end
    checks++;
    if (res32 !== exp) begin errors++; $display("FAIL ffxff got %h want %h", res32, exp); end
    clr32();

    for (int m = 0; m < 2; m++)
      for (int i = 0; i < 4; i++) begin
        go32(m[0], sa[i], sb[i]);
        wait32(lat);
        exp = q32.pop_front();
        checks++;
        if (lat < 0 || res32 !== exp) begin
          errors++; $display("FAIL zero m=%0d i=%0d got %h lat=%0d want %h", m, i, res32, lat, exp);
        end
        clr32();
      end

    go32(1, 32'h80000000, 32'h80000000);
    wait32(lat);
    exp = q32.pop_front();
    checks++;
    if (res32 !== exp) begin errors++; $display("FAIL min_sq got %h want %h", res32, exp); end
    clr32();
  endtask

  task automatic test_handshake();
    int lat;
    logic [63:0] exp;
    go32(1, 32'd12345, 32'hFFFF0001);
    repeat (5) @(posedge clk);
    #1 sm32 = 0; a32 = 32'hDEADBEEF; b32 = 32'h12345678; start32 = 1;
    @(posedge clk); #1 start32 = 0; a32 = 32'h1; b32 = 32'h1;
    wait32(lat);
    exp = q32.pop_front();
    checks++;
    if (lat !== 10 || res32 !== exp) begin
      errors++; $display("FAIL start_mid_exec got %h lat=%0d want %h lat=10", res32, lat, exp);
    end
    clr32();

    start32 = 1; clear32 = 1;
    @(posedge clk); #1 start32 = 0; clear32 = 0;
    repeat (3) @(posedge clk);
    #1 checks++;
    if (busy32 !== 1'b0 || done32 !== 1'b0) begin
      errors++; $display("FAIL start_clear_idle got busy=%b done=%b want 0 0", busy32, done32);
    end
  endtask

  task automatic test_abort();
    int lat;
    logic [63:0] exp;
    go32(0, 32'hCAFEF00D, 32'h0BADBEEF);
    repeat (6) @(posedge clk);
    #1 clr32();
    void'(q32.pop_back());
    checks++;
    if ({busy32, done32, res32} !== 66'b0) begin
      errors++; $display("FAIL clear_mid_exec got busy=%b done=%b res=%h want 0", busy32, done32, res32);
    end
    lat = 0;
    repeat (20) begin @(posedge clk); #1 if (done32) lat++; end
    checks++;
    if (lat !== 0) begin errors++; $display("FAIL no_done_after_abort got %0d done cycles want 0", lat); end
    go32(1, 32'h7FFFFFFF, 32'h80000001);
    wait32(lat);
    exp = q32.pop_front();
    checks++;
    if (res32 !== exp) begin errors++; $display("FAIL after_abort got %h want %h", res32, exp); end
    clr32();

    go32(1, 32'd77, 32'd88);
    repeat (5) @(posedge clk);
    #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    void'(q32.pop_back());
    checks++;
    if ({busy32, done32, res32} !== 66'b0) begin
      errors++; $display("FAIL reset_mid_exec got busy=%b done=%b res=%h want 0", busy32, done32, res32);
    end
  endtask

  task automatic test_width8();
    int lat;
    logic [15:0] exp;
    logic [7:0] ra, rb;
    go8(1, 8'h80, 8'h80);
    wait8(lat);
    exp = q8.pop_front();
    checks++;
    if (lat !== 4 || res8 !== exp) begin
      errors++; $display("FAIL w8_min_sq got %h lat=%0d want %h lat=4", res8, lat, exp);
    end
    clr8();
    go8(0, 8'hFF, 8'hFF);
    wait8(lat);
    exp = q8.pop_front();
    checks++;
    if (lat !== 5 || res8 !== exp) begin
      errors++; $display("FAIL w8_ffxff got %h lat=%0d want %h lat=5", res8, lat, exp);
    end
    clr8();
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < 1000; i++) begin
        ra = 8'($urandom); rb = 8'($urandom);
        go8(m[0], ra, rb);
        wait8(lat);
        exp = q8.pop_front();
        checks++;
        if (lat !== 4 + (1 - m) || res8 !== exp) begin
          errors++; $display("FAIL w8_rand s=%0d %h*%h got %h lat=%0d want %h", m, ra, rb, res8, lat, exp);
        end
        clr8();
      end
  endtask

  initial begin
    reset = 1;
    start32 = 0; clear32 = 0; sm32 = 0; a32 = '0; b32 = '0;
    start8 = 0; clear8 = 0; sm8 = 0; a8 = '0; b8 = '0;
    @(posedge clk); #1;
    test_reset();
    test_directed32();
    test_handshake();
    test_abort();
    test_width8();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
